// File: rtl/acc_writeback.sv
// Write-back stage of the accumulator datapath: commits decoded results to acc,
// the register file, the compare flag, or data memory via a req/ack handshake.
module acc_writeback #(
  parameter int DW      = 8,
  parameter int RAW     = 3,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [5:0]     op,
  input  logic [DW-1:0]  alu_result,
  input  logic [DW-1:0]  rs_data,
  input  logic [RAW-1:0] rd_addr,
  output logic [DW-1:0]  acc,
  output logic           flag,
  output logic           rf_we,
  output logic [RAW-1:0] rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  output logic           mem_req,
  output logic           mem_we,
  output logic [DW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic           mem_ack,
  input  logic [DW-1:0]  mem_rdata,
  output logic           wb_done,
  output logic           err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] GRP_ALU0 = 3'b000;
  localparam logic [2:0] GRP_MEM  = 3'b001;
  localparam logic [2:0] GRP_ALU1 = 3'b010;
  localparam logic [2:0] GRP_EQ   = 3'b100;
  localparam logic [2:0] GRP_MOV  = 3'b101;

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t         state_q;
  logic [CW-1:0]  wait_cnt_q;
  logic [DW-1:0]  acc_q;
  logic           flag_q;
  logic           rf_we_q;
  logic [RAW-1:0] rf_waddr_q;
  logic [DW-1:0]  rf_wdata_q;
  logic           mem_req_q;
  logic           mem_we_q;
  logic [DW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;
  logic           wb_done_q;
  logic           err_q;

  assign in_ready = (state_q == IDLE);

  // NOTE: all state updates use <= so every branch sees pre-edge values,
  // which is what lets MOV and STR capture the accumulator before it changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wb_done_q <= 1'b0;
      rf_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            wb_done_q <= 1'b1;
            case (op[5:3])
              GRP_ALU0: if (op[2:0] != 3'b111) acc_q <= alu_result;
              GRP_ALU1: acc_q  <= alu_result;
              GRP_EQ:   flag_q <= alu_result[0];
              GRP_MOV: begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= rd_addr;
                rf_wdata_q <= acc_q;
              end
              GRP_MEM: begin
                // Only LWR (000) and STR (001) touch memory; other sub-codes retire as nops.
                if (op[2:1] == 2'b00) begin
                  wb_done_q  <= 1'b0;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= op[0];
                  mem_addr_q <= rs_data;
                  if (op[0]) mem_wdata_q <= acc_q;
                  wait_cnt_q <= '0;
                  state_q    <= MEM_WAIT;
                end
              end
              default: ;
            endcase
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) acc_q <= mem_rdata;
            wb_done_q <= 1'b1;
            state_q   <= IDLE;
          end else if (wait_cnt_q == CNT_LAST) begin
            // Hung memory: abandon the access, keep acc, and latch the error.
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            wb_done_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign acc       = acc_q;
  assign flag      = flag_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_done   = wb_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_writeback.sv
// Scoreboard bench for acc_writeback: a transaction-level model predicts each
// retire and each memory access; a negedge monitor compares what the DUT presents.
module tb_acc_writeback;
  localparam int DW      = 8;
  localparam int RAW     = 3;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [5:0]     op;
  logic [DW-1:0]  alu_result;
  logic [DW-1:0]  rs_data;
  logic [RAW-1:0] rd_addr;
  logic [DW-1:0]  acc;
  logic           flag;
  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic           mem_req;
  logic           mem_we;
  logic [DW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_ack;
  logic [DW-1:0]  mem_rdata;
  logic           wb_done;
  logic           err;

  acc_writeback #(.DW(DW), .RAW(RAW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alu_result(alu_result), .rs_data(rs_data), .rd_addr(rd_addr),
    .acc(acc), .flag(flag), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_done(wb_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  acc;
    logic           flag;
    logic           err;
    logic           rf_we;
    logic [RAW-1:0] waddr;
    logic [DW-1:0]  wdata;
  } retire_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cycles;
  } memtx_t;

  retire_t exp_q[$];
  memtx_t  mem_q[$];

  int checks = 0;
  int errors = 0;

  // Architectural state of the reference model.
  logic [DW-1:0]  m_acc;
  logic           m_flag;
  logic           m_err;
  logic [RAW-1:0] m_waddr;
  logic [DW-1:0]  m_wdata;

  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_flag = 1'b0; m_err = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // lat: 0 = memory never acks; n = ack presented in the n-th wait cycle.
  task automatic issue(input logic [5:0] op_v, input logic [DW-1:0] alu_v,
                       input logic [DW-1:0] rs_v, input logic [RAW-1:0] rd_v,
                       input int lat, input logic [DW-1:0] rdata_v);
    retire_t r;
    memtx_t  m;
    logic    is_mem;
    is_mem  = (op_v[5:3] == 3'b001) && (op_v[2:1] == 2'b00);
    r.rf_we = 1'b0;
    case (op_v[5:3])
      3'b000: if (op_v[2:0] != 3'b111) m_acc = alu_v;
      3'b010: m_acc = alu_v;
      3'b100: m_flag = alu_v[0];
      3'b101: begin m_waddr = rd_v; m_wdata = m_acc; r.rf_we = 1'b1; end
      default: ;
    endcase
    if (is_mem) begin
      m.we = op_v[0]; m.addr = rs_v; m.wdata = m_acc;
      m.cycles = (lat == 0) ? TIMEOUT : lat;
      mem_q.push_back(m);
      if (lat == 0) m_err = 1'b1;
      else if (!op_v[0]) m_acc = rdata_v;
    end
    r.acc = m_acc; r.flag = m_flag; r.err = m_err; r.waddr = m_waddr; r.wdata = m_wdata;
    exp_q.push_back(r);

    in_valid = 1'b1; op = op_v; alu_result = alu_v; rs_data = rs_v; rd_addr = rd_v;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ack = 1'b0; op = 6'($urandom); alu_result = DW'($urandom);
    if (is_mem) begin
      if (lat == 0) begin
        repeat (TIMEOUT) @(posedge clk);
        #1;
      end else begin
        repeat (lat - 1) begin @(posedge clk); #1; end
        mem_ack = 1'b1; mem_rdata = rdata_v;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = DW'($urandom);
      end
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0; op = 6'($urandom);
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  // Monitor: retire scoreboard, memory-access scoreboard, handshake invariants.
  logic          run_active = 1'b0;
  int            run_cnt;
  logic [DW-1:0] run_addr;
  logic          run_we;
  logic [DW-1:0] run_wdata;

  always @(negedge clk) begin
    if (mon_en) begin
      retire_t r;
      memtx_t  m;
      check("in_ready_vs_mem_req", in_ready, !mem_req);
      if (rf_we && !wb_done) check("rf_we_without_retire", 1, 0);
      if (wb_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("retire_acc", acc, r.acc);
          check("retire_flag", flag, r.flag);
          check("retire_err", err, r.err);
          check("retire_rf_we", rf_we, r.rf_we);
          check("retire_rf_waddr", rf_waddr, r.waddr);
          check("retire_rf_wdata", rf_wdata, r.wdata);
        end
      end
      if (mem_req) begin
        if (!run_active) begin
          run_active = 1'b1; run_cnt = 1;
          run_addr = mem_addr; run_we = mem_we; run_wdata = mem_wdata;
        end else begin
          run_cnt++;
          check("mem_addr_stable", mem_addr, run_addr);
          check("mem_we_stable", mem_we, run_we);
          check("mem_wdata_stable", mem_wdata, run_wdata);
        end
      end else if (run_active) begin
        run_active = 1'b0;
        if (mem_q.size() == 0) begin
          check("unexpected_mem_access", 1, 0);
        end else begin
          m = mem_q.pop_front();
          check("mem_req_cycles", run_cnt, m.cycles);
          check("mem_addr", run_addr, m.addr);
          check("mem_we", run_we, m.we);
          if (m.we) check("mem_wdata", run_wdata, m.wdata);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int lat;
    logic [5:0] op_v;
    memtx_t m;

    // Reset held two cycles with an instruction presented.
    rst_n = 1'b0; in_valid = 1'b1; op = 6'b000000; alu_result = 8'hFF;
    rs_data = '0; rd_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_acc", acc, 0);
      check("reset_err", err, 0);
      check("reset_wb_done", wb_done, 0);
      check("reset_mem_req", mem_req, 0);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    check("reset_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // ALU write then MOV of the pre-edge accumulator, back to back.
    issue(6'b010000, 8'h5A, 8'h00, 3'd0, 0, 8'h00);
    issue(6'b101000, 8'h00, 8'h00, 3'd3, 0, 8'h00);
    // Load with ack in the third wait cycle.
    issue(6'b001000, 8'h00, 8'h20, 3'd0, 3, 8'hC3);
    // Store with first-cycle ack.
    issue(6'b010000, 8'h11, 8'h00, 3'd0, 0, 8'h00);
    issue(6'b001001, 8'h00, 8'h40, 3'd0, 1, 8'hEE);
    // Ack coinciding with the timeout cycle: completes, no error.
    issue(6'b001000, 8'h00, 8'h33, 3'd0, TIMEOUT, 8'h77);
    // Hung load, then a compare still updates the flag.
    issue(6'b001000, 8'h00, 8'h55, 3'd0, 0, 8'h00);
    issue(6'b100000, 8'h01, 8'h00, 3'd0, 0, 8'h00);
    issue(6'b000111, 8'h99, 8'h00, 3'd0, 0, 8'h00);

    // Reset in the second wait cycle of a load drops it without retire.
    m.we = 1'b0; m.addr = 8'h66; m.wdata = '0; m.cycles = 2;
    mem_q.push_back(m);
    in_valid = 1'b1; op = 6'b001000; rs_data = 8'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_wb_done", wb_done, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_acc", acc, 0);
    check("rst_mid_err", err, 0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hAB;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_acc", acc, 0);
    check("late_ack_wb_done", wb_done, 0);

    // Randomised instruction stream.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) op_v = {5'b00100, 1'($urandom_range(0, 1))};
      else op_v = 6'($urandom);
      r = $urandom_range(0, 19);
      if (r == 0) lat = 0;
      else if (r == 1) lat = TIMEOUT;
      else lat = $urandom_range(1, 5);
      issue(op_v, DW'($urandom), DW'($urandom), RAW'($urandom), lat, DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    repeat (4) idle_cycle();
    check("retire_queue_drained", exp_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
